// File: rtl/wb_cmd_initiator.sv
// Wishbone classic initiator: one bus cycle per valid/ready command, with a bounded
// ACK wait that aborts the cycle and returns an error response on timeout.
module wb_cmd_initiator #(
    parameter int          ADDRWIDTH          = 17,
    parameter int          DATAWIDTH          = 32,
    parameter int          TIMEOUT_CYCLES     = 16,
    parameter int          TIMEOUT_CNTR_WIDTH = 5,
    parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC
) (
    input  logic                 WB_CLK,
    input  logic                 WB_RST,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [ADDRWIDTH-1:0] cmd_adr_i,
    input  logic [DATAWIDTH-1:0] cmd_dat_i,
    input  logic [3:0]           cmd_byte_stb_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATAWIDTH-1:0] rsp_dat_o,
    output logic                 rsp_err_o,
    output logic [ADDRWIDTH-1:0] WBs_ADR_o,
    output logic                 WBs_CYC_o,
    output logic                 WBs_STB_o,
    output logic                 WBs_WE_o,
    output logic                 WBs_RD_o,
    output logic [3:0]           WBs_BYTE_STB_o,
    output logic [DATAWIDTH-1:0] WBs_WR_DAT_o,
    input  logic [DATAWIDTH-1:0] WBs_RD_DAT_i,
    input  logic                 WBs_ACK_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [TIMEOUT_CNTR_WIDTH-1:0] CNT_LAST = TIMEOUT_CNTR_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                        state_r;
    logic [TIMEOUT_CNTR_WIDTH-1:0] cnt_r;

    assign cmd_ready_o = (state_r == ST_IDLE);

    // Command/bus/response sequencer; every output except cmd_ready_o is a register here.
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            state_r        <= ST_IDLE;
            cnt_r          <= '0;
            rsp_valid_o    <= 1'b0;
            rsp_err_o      <= 1'b0;
            rsp_dat_o      <= '0;
            WBs_ADR_o      <= '0;
            WBs_CYC_o      <= 1'b0;
            WBs_STB_o      <= 1'b0;
            WBs_WE_o       <= 1'b0;
            WBs_RD_o       <= 1'b0;
            WBs_BYTE_STB_o <= 4'h0;
            WBs_WR_DAT_o   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        state_r        <= ST_BUS;
                        cnt_r          <= '0;
                        WBs_CYC_o      <= 1'b1;
                        WBs_STB_o      <= 1'b1;
                        WBs_WE_o       <= cmd_we_i;
                        WBs_RD_o       <= ~cmd_we_i;
                        WBs_ADR_o      <= cmd_adr_i;
                        WBs_WR_DAT_o   <= cmd_dat_i;
                        WBs_BYTE_STB_o <= cmd_we_i ? cmd_byte_stb_i : 4'hF;
                    end
                end
                ST_BUS: begin
                    // ACK is checked before the timeout so a last-cycle ACK still succeeds.
                    if (WBs_ACK_i) begin
                        state_r        <= ST_RESP;
                        WBs_CYC_o      <= 1'b0;
                        WBs_STB_o      <= 1'b0;
                        WBs_WE_o       <= 1'b0;
                        WBs_RD_o       <= 1'b0;
                        WBs_BYTE_STB_o <= 4'h0;
                        rsp_valid_o    <= 1'b1;
                        rsp_err_o      <= 1'b0;
                        rsp_dat_o      <= WBs_WE_o ? {DATAWIDTH{1'b0}} : WBs_RD_DAT_i;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r        <= ST_RESP;
                        WBs_CYC_o      <= 1'b0;
                        WBs_STB_o      <= 1'b0;
                        WBs_WE_o       <= 1'b0;
                        WBs_RD_o       <= 1'b0;
                        WBs_BYTE_STB_o <= 4'h0;
                        rsp_valid_o    <= 1'b1;
                        rsp_err_o      <= 1'b1;
                        rsp_dat_o      <= DEFAULT_READ_VALUE;
                    end else begin
                        cnt_r <= cnt_r + TIMEOUT_CNTR_WIDTH'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_o <= 1'b0;
                        rsp_err_o   <= 1'b0;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    cnt_r          <= '0;
                    rsp_valid_o    <= 1'b0;
                    rsp_err_o      <= 1'b0;
                    WBs_CYC_o      <= 1'b0;
                    WBs_STB_o      <= 1'b0;
                    WBs_WE_o       <= 1'b0;
                    WBs_RD_o       <= 1'b0;
                    WBs_BYTE_STB_o <= 4'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed, table-driven bench for wb_cmd_initiator with a small delayed-ACK responder.
module tb_wb_cmd_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [16:0] cmd_adr = 17'h0;
    logic [31:0] cmd_dat = 32'h0;
    logic [3:0]  cmd_stb = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic [16:0] wb_adr;
    logic        wb_cyc, wb_stb, wb_we, wb_rd;
    logic [3:0]  wb_bstb;
    logic [31:0] wb_wr_dat;
    logic [31:0] wb_rd_dat = 32'h0;
    logic        wb_ack = 1'b0;

    int total = 0;
    int bad   = 0;

    wb_cmd_initiator dut (
        .WB_CLK(clk), .WB_RST(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_byte_stb_i(cmd_stb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
        .WBs_ADR_o(wb_adr), .WBs_CYC_o(wb_cyc), .WBs_STB_o(wb_stb), .WBs_WE_o(wb_we),
        .WBs_RD_o(wb_rd), .WBs_BYTE_STB_o(wb_bstb), .WBs_WR_DAT_o(wb_wr_dat),
        .WBs_RD_DAT_i(wb_rd_dat), .WBs_ACK_i(wb_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [16:0] adr;
        logic [31:0] dat;
        logic [3:0]  stb;
        int          delay;     // ACK in this cycle index of CYC; large = never
        logic [31:0] rd;
        logic [31:0] exp_dat;
        logic        exp_err;
        logic [3:0]  exp_bstb;
        int          exp_cyc;
        int          bp;        // cycles rsp_ready held low (late ACK driven meanwhile)
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one command; starts and ends just after a falling edge.
    task automatic run_txn(input int i);
        vec_t v;
        int   n;
        logic [31:0] held;
        v = tbl[i];
        cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_stb = v.stb;
        wb_rd_dat = v.rd;
        cmd_valid = 1'b1;
        chk($sformatf("v%0d cmd_ready", i), {63'h0, cmd_ready}, 64'h1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (wb_cyc === 1'b1 && n < 40) begin
            if (n == 0) begin
                chk($sformatf("v%0d adr", i), {47'h0, wb_adr}, {47'h0, v.adr});
                chk($sformatf("v%0d we_rd_stb", i), {61'h0, wb_we, wb_rd, wb_stb}, {61'h0, v.we, ~v.we, 1'b1});
                chk($sformatf("v%0d bstb", i), {60'h0, wb_bstb}, {60'h0, v.exp_bstb});
                chk($sformatf("v%0d wr_dat", i), {32'h0, wb_wr_dat}, {32'h0, v.dat});
                chk($sformatf("v%0d rsp_early", i), {63'h0, rsp_valid}, 64'h0);
            end
            wb_ack = (n == v.delay);
            @(posedge clk); @(negedge clk);
            n++;
        end
        wb_ack = 1'b0;
        chk($sformatf("v%0d cyc_len", i), 64'(n), 64'(v.exp_cyc));
        chk($sformatf("v%0d rsp_valid", i), {63'h0, rsp_valid}, 64'h1);
        chk($sformatf("v%0d rsp_dat", i), {32'h0, rsp_dat}, {32'h0, v.exp_dat});
        chk($sformatf("v%0d rsp_err", i), {63'h0, rsp_err}, {63'h0, v.exp_err});
        chk($sformatf("v%0d bus_idle", i), {59'h0, wb_stb, wb_we, wb_rd, |wb_bstb, wb_cyc}, 64'h0);
        held = rsp_dat;
        for (int k = 0; k < v.bp; k++) begin
            wb_ack = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d bp_hold", i), {30'h0, rsp_valid, rsp_err, rsp_dat},
                {30'h0, 1'b1, v.exp_err, held});
            chk($sformatf("v%0d bp_block", i), {62'h0, cmd_ready, wb_cyc}, 64'h0);
        end
        wb_ack = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d after_hs", i), {61'h0, rsp_valid, rsp_err, cmd_ready}, 64'h1);
    endtask

    initial begin
        //          we    adr        dat            stb   dly rd             exp_dat        err   bstb  cyc bp
        tbl[0] = '{1'b1, 17'h02004, 32'h0000_00FF, 4'hF, 0,  32'h0,         32'h0,         1'b0, 4'hF, 1,  0};
        tbl[1] = '{1'b0, 17'h051F8, 32'h0,         4'h3, 3,  32'h1234_5678, 32'h1234_5678, 1'b0, 4'hF, 4,  0};
        tbl[2] = '{1'b0, 17'h1FFFC, 32'h0,         4'h0, 99, 32'h5555_AAAA, 32'hBADF_ABAC, 1'b1, 4'hF, 16, 3};
        tbl[3] = '{1'b0, 17'h00010, 32'h0,         4'h1, 15, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0, 4'hF, 16, 0};
        tbl[4] = '{1'b1, 17'h00103, 32'hA5A5_5A5A, 4'h6, 1,  32'hDEAD_BEEF, 32'h0,         1'b0, 4'h6, 2,  5};
        tbl[5] = '{1'b0, 17'h00002, 32'h0,         4'h8, 0,  32'h0000_0001, 32'h0000_0001, 1'b0, 4'hF, 1,  0};

        #2;
        chk("reset_outs", {30'h0, rsp_valid, rsp_err, rsp_dat}, 64'h0);
        chk("reset_bus", {12'h0, wb_adr, wb_cyc, wb_stb, wb_we, wb_rd, wb_bstb, wb_wr_dat}, 64'h0);
        chk("reset_ready", {63'h0, cmd_ready}, 64'h1);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_txn(i);

        // Reset in the second BUS cycle of a read whose ACK would come much later.
        cmd_we = 1'b0; cmd_adr = 17'h00400; cmd_stb = 4'hF; cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_cyc", {63'h0, wb_cyc}, 64'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_bus", {12'h0, wb_adr, wb_cyc, wb_stb, wb_we, wb_rd, wb_bstb, wb_wr_dat}, 64'h0);
        chk("rst_async_rsp", {63'h0, rsp_valid}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {63'h0, cmd_ready}, 64'h1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("rst_no_rsp", {62'h0, rsp_valid, wb_cyc}, 64'h0);
        end
        run_txn(0);
        run_txn(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
